// File: rtl/cmd_conditioner.sv
// Synchronizes and debounces a raw 3-bit command bus, publishing each stable
// value as a registered command with a one-cycle strobe and a post-commit lockout.
module cmd_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] raw_in,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  output logic       busy
);

  localparam int MAXC = (DEBOUNCE_CYCLES > LOCKOUT_CYCLES) ? DEBOUNCE_CYCLES : LOCKOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LO_LAST = (LOCKOUT_CYCLES > 0) ? CW'(LOCKOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SETTLE  = 2'b01,
    LOCKOUT = 2'b10,
    RECOVER = 2'b11
  } state_e;

  // Plain vector so every encoding, including the unreachable one, is representable.
  logic [1:0]    state, state_nxt;
  logic [2:0]    sync1, sync_in;
  logic [2:0]    cand, cand_nxt;
  logic [2:0]    cmd_nxt;
  logic          valid_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 3'b000;
      sync_in <= 3'b000;
    end else begin
      sync1   <= raw_in;
      sync_in <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= 3'b000;
      cnt       <= '0;
      cmd       <= 3'b000;
      cmd_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      cmd       <= cmd_nxt;
      cmd_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    cmd_nxt   = cmd;
    valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (sync_in != cmd) begin
          cand_nxt  = sync_in;
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (sync_in != cand) begin
          // Returning to the committed value abandons the candidate silently.
          if (sync_in == cmd) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cand_nxt = sync_in;
            cnt_nxt  = '0;
          end
        end else if (cnt == DB_LAST) begin
          cmd_nxt   = cand;
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = (LOCKOUT_CYCLES > 0) ? LOCKOUT : IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LOCKOUT: begin
        if (LOCKOUT_CYCLES == 0 || cnt == LO_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cmd_conditioner.sv
// Randomized and directed checks of cmd_conditioner against a timestamp-based
// reference model of the debounce/lockout rules.
module tb_cmd_conditioner;

  localparam int D = 4;
  localparam int L = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] raw_in;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int nstrobe = 0;

  cmd_conditioner #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L)) dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
    .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: edge index, sampled-input history, candidate start edge,
  // and the first edge at which input is looked at again after a commit.
  int         e;
  logic [2:0] ms1, ms2, m_cmd, m_cand;
  bit         m_valid, m_trk, m_upset;
  int         m_start, m_free;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    e = 0; ms1 = 3'b0; ms2 = 3'b0; m_cmd = 3'b0; m_cand = 3'b0;
    m_valid = 1'b0; m_trk = 1'b0; m_upset = 1'b0; m_start = 0; m_free = 0;
  endtask

  task automatic model_step();
    logic [2:0] s;
    e++;
    s = ms2;
    ms2 = ms1;
    ms1 = raw_in;
    m_valid = 1'b0;
    if (m_upset) begin
      m_upset = 1'b0;
    end else if (e >= m_free) begin
      if (!m_trk) begin
        if (s != m_cmd) begin
          m_trk = 1'b1; m_cand = s; m_start = e;
        end
      end else if (s != m_cand) begin
        if (s == m_cmd) m_trk = 1'b0;
        else begin m_cand = s; m_start = e; end
      end else if (e - m_start == D) begin
        m_cmd = m_cand; m_valid = 1'b1; m_trk = 1'b0; m_free = e + L + 1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    if (cmd_valid === 1'b1) nstrobe++;
    chk("cmd", 32'(cmd), 32'(m_cmd));
    chk("cmd_valid", 32'(cmd_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_trk || (e + 1 < m_free)));
  endtask

  task automatic hold(input logic [2:0] v, input int n);
    raw_in = v;
    repeat (n) cyc();
  endtask

  initial begin
    raw_in = 3'b111;
    rst_n  = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("rst_cmd", 32'(cmd), 0);
      chk("rst_valid", 32'(cmd_valid), 0);
      chk("rst_busy", 32'(busy), 0);
    end
    rst_n = 1'b1;
    hold(3'b000, 3);

    // Clean commit of 101
    nstrobe = 0;
    hold(3'b101, 10);
    chk("clean_cmd", 32'(cmd), 32'h5);
    chk("clean_strobes", nstrobe, 1);
    hold(3'b000, 10);

    // Short glitch never commits
    nstrobe = 0;
    hold(3'b011, 3);
    hold(3'b000, 8);
    chk("glitch_cmd", 32'(cmd), 0);
    chk("glitch_strobes", nstrobe, 0);
    chk("glitch_idle", 32'(busy), 0);

    // Bounce restarts the count
    nstrobe = 0;
    hold(3'b010, 2);
    hold(3'b110, 1);
    hold(3'b010, 12);
    chk("bounce_cmd", 32'(cmd), 32'h2);
    chk("bounce_strobes", nstrobe, 1);

    // Change arriving during lockout is deferred, then committed
    nstrobe = 0;
    hold(3'b001, 6);
    hold(3'b100, 14);
    chk("lock_cmd", 32'(cmd), 32'h4);
    chk("lock_strobes", nstrobe, 2);

    // Reset while settling
    nstrobe = 0;
    hold(3'b111, 4);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_cmd", 32'(cmd), 0);
    chk("midrst_busy", 32'(busy), 0);
    raw_in = 3'b000;
    cyc();
    cyc();
    rst_n = 1'b1;
    hold(3'b000, 6);
    chk("midrst_after", 32'(cmd), 0);
    chk("midrst_strobes", nstrobe, 0);

    // Upset into the unused encoding recovers on the next edge
    hold(3'b110, 12);
    force dut.state = 2'b11;
    #1;
    release dut.state;
    #1;
    chk("upset_busy", 32'(busy), 1);
    m_upset = 1'b1;
    cyc();
    chk("upset_cmd", 32'(cmd), 32'h6);
    chk("upset_valid", 32'(cmd_valid), 0);
    chk("upset_idle", 32'(busy), 0);

    // Randomized segments of varying length
    repeat (400) begin
      hold(3'($urandom_range(0, 7)), int'($urandom_range(1, 9)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
